datapath_share_arb: RTL

Round-robin arbiter and sequencer that shares one registered AND/OR operand datapath among three requesters. Each requester presents two DW-bit operands and a mode bit. The block grants one requester at a time, captures its operands, computes the result, and holds it on a valid/ready output port until the consumer accepts it. It sits in front of the lint-clean datapath and replaces direct, multi-driven access to that datapath.

---
 rtl/datapath_share_arb.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/datapath_share_arb.sv
// rtl/datapath_share_arb.sv - round-robin arbiter sharing one registered AND/OR operand datapath
// Three requesters; one grant at a time; result held on a valid/ready port until accepted.
module datapath_share_arb #(
  parameter int DW = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [2:0]      req,
  input  logic [3*DW-1:0] req_a,
  input  logic [3*DW-1:0] req_b,
  input  logic [2:0]      req_mode,
  output logic [2:0]      gnt,
  output logic            busy,
  output logic            res_valid,
  output logic [DW-1:0]   res_data,
  output logic [1:0]      res_id,
  input  logic            res_ready,
  output logic [7:0]      done_cnt
);

  typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

  state_t        state_q, state_d;
  logic [1:0]    last_q, last_d;
  logic [DW-1:0] op_a_q, op_a_d;
  logic [DW-1:0] op_b_q, op_b_d;
  logic          op_mode_q, op_mode_d;
  logic [2:0]    gnt_q, gnt_d;
  logic          busy_q, busy_d;
  logic          res_valid_q, res_valid_d;
  logic [DW-1:0] res_data_q, res_data_d;
  logic [1:0]    res_id_q, res_id_d;
  logic [7:0]    done_cnt_q, done_cnt_d;

  logic [1:0]    pri0, pri1, pri2, winner;
  logic [DW-1:0] sel_a, sel_b;
  logic          sel_mode;

  // Search order starts one past the last winner and wraps.
  always_comb begin
    case (last_q)
      2'd0:    begin pri0 = 2'd1; pri1 = 2'd2; pri2 = 2'd0; end
      2'd1:    begin pri0 = 2'd2; pri1 = 2'd0; pri2 = 2'd1; end
      default: begin pri0 = 2'd0; pri1 = 2'd1; pri2 = 2'd2; end
    endcase
    if (req[pri0])      winner = pri0;
    else if (req[pri1]) winner = pri1;
    else                winner = pri2;
  end

  always_comb begin
    case (winner)
      2'd1: begin
        sel_a    = req_a[DW +: DW];
        sel_b    = req_b[DW +: DW];
        sel_mode = req_mode[1];
      end
      2'd2: begin
        sel_a    = req_a[2*DW +: DW];
        sel_b    = req_b[2*DW +: DW];
        sel_mode = req_mode[2];
      end
      default: begin
        sel_a    = req_a[0 +: DW];
        sel_b    = req_b[0 +: DW];
        sel_mode = req_mode[0];
      end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    op_mode_d   = op_mode_q;
    gnt_d       = 3'b000;
    busy_d      = busy_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_id_d    = res_id_q;
    done_cnt_d  = done_cnt_q;
    case (state_q)
      IDLE: begin
        if (req != 3'b000) begin
          gnt_d     = 3'b001 << winner;
          op_a_d    = sel_a;
          op_b_d    = sel_b;
          op_mode_d = sel_mode;
          last_d    = winner;
          busy_d    = 1'b1;
          state_d   = EXEC;
        end
      end
      EXEC: begin
        res_data_d  = op_mode_q ? (op_a_q & op_b_q) : (op_a_q | op_b_q);
        res_id_d    = last_q;
        res_valid_d = 1'b1;
        state_d     = HOLD;
      end
      HOLD: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          busy_d      = 1'b0;
          done_cnt_d  = done_cnt_q + 8'd1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // last resets to 2 so requester 0 is searched first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_q      <= 2'd2;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_mode_q   <= 1'b0;
      gnt_q       <= 3'b000;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_id_q    <= 2'd0;
      done_cnt_q  <= 8'd0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      op_mode_q   <= op_mode_d;
      gnt_q       <= gnt_d;
      busy_q      <= busy_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_id_q    <= res_id_d;
      done_cnt_q  <= done_cnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign busy      = busy_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_id    = res_id_q;
  assign done_cnt  = done_cnt_q;

endmodule
